// File: rtl/debounce_edge.sv
// debounce_edge: glitch-rejecting debouncer with clean level, edge strobes and saturating press counter
module debounce_edge #(
  parameter int STABLE_CYCLES = 1000,
  parameter int CNT_W         = 10,
  parameter int EVT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             clr_count,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic [EVT_W-1:0] press_count
);
  typedef enum logic [1:0] {LOW, WAIT_HIGH, HIGH, WAIT_LOW} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d, rise_q, rise_d, fall_q, fall_d;
  logic [EVT_W-1:0] press_q, press_d;
  logic             done;
  assign done = cnt_q == LAST;
  // next state: a new value must hold STABLE_CYCLES+1 samples; any opposite sample aborts the wait
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      LOW: if (din) begin
        state_d = WAIT_HIGH;
        cnt_d   = '0;
      end
      WAIT_HIGH: if (!din) state_d = LOW;
        else if (done) begin
          state_d = HIGH;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      HIGH: if (!din) begin
        state_d = WAIT_LOW;
        cnt_d   = '0;
      end
      WAIT_LOW: if (din) state_d = HIGH;
        else if (done) begin
          state_d = LOW;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      default: state_d = LOW;
    endcase
    press_d = clr_count ? '0 : (rise_d && press_q != '1) ? press_q + 1'b1 : press_q;
  end
  // state and registered outputs, cleared immediately by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      press_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      press_q <= press_d;
    end
  end
  assign level       = level_q;
  assign rise        = rise_q;
  assign fall        = fall_q;
  assign press_count = press_q;
endmodule

// File: tb/tb_debounce_edge.sv
// tb_debounce_edge: table, directed and randomized checks against a run-length reference model
module tb_debounce_edge;
  localparam int SC = 4;
  logic clk = 1'b0, reset = 1'b1, din = 1'b0, clr_count = 1'b0;
  logic level, rise, fall, level2, rise2, fall2;
  logic [7:0] press8;
  logic [1:0] press2;
  int total = 0, passed = 0;
  int run = 0, m_p8 = 0, m_p2 = 0;
  bit m_level = 0, m_rise = 0, m_fall = 0;

  always #5 clk = ~clk;

  debounce_edge #(.STABLE_CYCLES(SC), .CNT_W(3), .EVT_W(8)) u8 (
    .clk(clk), .reset(reset), .din(din), .clr_count(clr_count),
    .level(level), .rise(rise), .fall(fall), .press_count(press8));
  debounce_edge #(.STABLE_CYCLES(SC), .CNT_W(3), .EVT_W(2)) u2 (
    .clk(clk), .reset(reset), .din(din), .clr_count(clr_count),
    .level(level2), .rise(rise2), .fall(fall2), .press_count(press2));

  typedef struct {bit d; bit c; bit lv; bit r; bit f; int pc;} vec_t;
  vec_t tbl[$];

  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // level flips once STABLE+1 consecutive samples disagree with it
  function automatic void model(bit d, bit c);
    m_rise = 0;
    m_fall = 0;
    run = (d != m_level) ? run + 1 : 0;
    if (run == SC + 1) begin
      m_level = d;
      m_rise = d;
      m_fall = !d;
      run = 0;
    end
    m_p8 = c ? 0 : m_rise ? (m_p8 < 255 ? m_p8 + 1 : 255) : m_p8;
    m_p2 = c ? 0 : m_rise ? (m_p2 < 3 ? m_p2 + 1 : 3) : m_p2;
  endfunction

  task automatic step(bit d, bit c = 0);
    din = d;
    clr_count = c;
    @(posedge clk);
    model(d, c);
    #1;
    chk("level", int'(level), int'(m_level));
    chk("rise", int'(rise), int'(m_rise));
    chk("fall", int'(fall), int'(m_fall));
    chk("press8", int'(press8), m_p8);
    chk("level2", int'(level2), int'(m_level));
    chk("press2", int'(press2), m_p2);
    chk("rise_fall_excl", int'(rise & fall), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_level", int'(level), 0);
    chk("rst_rise", int'(rise), 0);
    chk("rst_fall", int'(fall), 0);
    chk("rst_press8", int'(press8), 0);
    chk("rst_press2", int'(press2), 0);
    run = 0; m_level = 0; m_rise = 0; m_fall = 0; m_p8 = 0; m_p2 = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic press();
    repeat (SC + 1) step(1);
    repeat (SC + 1) step(0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (SC) tbl.push_back('{1, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 1, 1, 0, 1});
    tbl.push_back('{1, 0, 1, 0, 0, 1});
    tbl.push_back('{0, 0, 1, 0, 0, 1});
    tbl.push_back('{1, 0, 1, 0, 0, 1});
    repeat (SC) tbl.push_back('{0, 0, 1, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 1, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 1});
    repeat (SC) tbl.push_back('{1, 0, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 1});
    repeat (SC) tbl.push_back('{1, 0, 0, 0, 0, 1});
    tbl.push_back('{1, 0, 1, 1, 0, 2});
    tbl.push_back('{1, 1, 1, 0, 0, 0});
    foreach (tbl[i]) begin
      step(tbl[i].d, tbl[i].c);
      chk($sformatf("tbl%0d_level", i), int'(level), int'(tbl[i].lv));
      chk($sformatf("tbl%0d_rise", i), int'(rise), int'(tbl[i].r));
      chk($sformatf("tbl%0d_fall", i), int'(fall), int'(tbl[i].f));
      chk($sformatf("tbl%0d_press", i), int'(press8), tbl[i].pc);
    end
    repeat (SC + 1) step(0);
    chk("released_level", int'(level), 0);
    press(); chk("sat_p1", int'(press2), 1);
    press(); chk("sat_p2", int'(press2), 2);
    press(); chk("sat_p3", int'(press2), 3);
    press(); chk("sat_p4", int'(press2), 3);
    repeat (SC + 1) step(1);
    chk("pre_rst_level", int'(level), 1);
    chk("pre_rst_press8", int'(press8), 5);
    pulse_reset();
    press();
    chk("clr_pre", int'(press2), 1);
    repeat (SC) step(1);
    step(1, 1);
    chk("clr_rise", int'(rise2), 1);
    chk("clr_wins", int'(press2), 0);
    repeat (SC + 1) step(0);
    repeat (3) step(1);
    pulse_reset();
    repeat (SC) step(1);
    chk("mid_rst_hold", int'(level), 0);
    step(1);
    chk("mid_rst_level", int'(level), 1);
    chk("mid_rst_rise", int'(rise), 1);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) pulse_reset();
      step(($urandom_range(0, 5) == 0) ? ~din : din, $urandom_range(0, 39) == 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
